uart_tx_arbiter: RTL

// Shares one UART transmitter (tx_start/tx_busy control, parallel tx_data) between NUM_REQ

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares a single UART transmitter between NUM_REQ byte producers. A round-robin
// arbiter picks one pending requester while idle. It latches that requester's byte
// and raises tx_start as a frame enable. The enable is held until the transmitter
// reports the end of the frame through tx_busy. The winner then gets a done pulse.
// A one-cycle gap follows every frame so the transmitter always sees tx_start low
// before the next frame begins.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req          per-requester level request, held until ack
//   req_data     requester i's byte at [i*DATA_W +: DATA_W]
//   ack          one-cycle pulse: byte of requester i latched
//   done         one-cycle pulse: requester i frame finished or timed out
//   err_timeout  one-cycle pulse alongside done when tx_busy never rose
//   grant_id     index of the current or last owner
//   active       high from LAUNCH through GAP
//   tx_start     registered frame enable to the transmitter
//   tx_data      latched byte, stable while active
//   tx_busy      transmitter busy status

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err_timeout,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       active,
    output logic                       tx_start,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // A disabled timeout still needs a counter of at least one bit to stay legal.
    localparam int CNT_W = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [IDX_W:0]   NUM_REQ_W   = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        XMIT,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               active_q, active_d;
    logic               tx_start_q, tx_start_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  req_bytes [NUM_REQ];
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W:0]     rr_idx;
    logic [IDX_W:0]     ptr_sum;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [CNT_W-1:0]   cnt_inc;

    // Split the flat request data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin search.
    // The scan starts at the pointer and wraps modulo NUM_REQ. The extra index bit
    // lets the sum exceed NUM_REQ before it is folded back.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        rr_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_idx = {1'b0, ptr_q} + (IDX_W + 1)'(i);
            if (rr_idx >= NUM_REQ_W) begin
                rr_idx = rr_idx - NUM_REQ_W;
            end
            if (!found && req[rr_idx[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = rr_idx[IDX_W-1:0];
            end
        end
        ptr_sum = {1'b0, win} + (IDX_W + 1)'(1);
        ptr_nxt = (ptr_sum == NUM_REQ_W) ? '0 : ptr_sum[IDX_W-1:0];
    end

    // The busy-wait counter saturates at its maximum instead of wrapping.
    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and next-output logic.
    // Every output is a flop, so each value computed here appears one edge later.
    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        grant_d    = grant_q;
        active_d   = active_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ack_d[win] = 1'b1;
                    grant_d    = win;
                    tx_data_d  = req_bytes[win];
                    tx_start_d = 1'b1;
                    active_d   = 1'b1;
                    ptr_d      = ptr_nxt;
                    cnt_d      = '0;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                if (tx_busy) begin
                    state_d = XMIT;
                end else begin
                    cnt_d = cnt_inc;
                    if ((BUSY_TIMEOUT != 0) && (cnt_inc == TIMEOUT_CNT)) begin
                        tx_start_d       = 1'b0;
                        done_d[grant_q]  = 1'b1;
                        err_d            = 1'b1;
                        state_d          = GAP;
                    end
                end
            end
            XMIT: begin
                tx_start_d = 1'b1;
                if (!tx_busy) begin
                    tx_start_d      = 1'b0;
                    done_d[grant_q] = 1'b1;
                    state_d         = GAP;
                end
            end
            GAP: begin
                tx_start_d = 1'b0;
                active_d   = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. A synchronous reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            grant_q    <= '0;
            active_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            grant_q    <= grant_d;
            active_q   <= active_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign grant_id    = grant_q;
    assign active      = active_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;

endmodule
